// File: rtl/servo_pos_driver.sv
// rtl/servo_pos_driver.sv - five-joint servo position stepper with shared-frame PWM outputs
// Positions step on a periodic tick; pulse widths are latched at every frame start.
module servo_pos_driver #(
  parameter int unsigned STEP_DIV   = 500000,
  parameter int unsigned PWM_PERIOD = 1000000,
  parameter int unsigned PULSE_MIN  = 50000,
  parameter int unsigned PULSE_STEP = 196,
  parameter logic [7:0]  POS_INIT   = 8'h80,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic [1:0] btn3,
  input  logic [1:0] btn4,
  input  logic [1:0] btn5,
  output logic [7:0] pos1,
  output logic [7:0] pos2,
  output logic [7:0] pos3,
  output logic [7:0] pos4,
  output logic [7:0] pos5,
  output logic [4:0] pwm,
  output logic [4:0] lim
);

  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] P_MIN      = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] P_STEP     = CNT_W'(PULSE_STEP);
  localparam logic [CNT_W-1:0] W_INIT     = P_MIN + CNT_W'(POS_INIT) * P_STEP;

  typedef enum logic {IDLE_WAIT = 1'b0, STEP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic [7:0]        pos_q [5];
  logic [7:0]        pos_d [5];
  logic [CNT_W-1:0]  width_q [5];
  logic [CNT_W-1:0]  width_d [5];
  logic [4:0]        pwm_q, pwm_d;
  logic [1:0]        btn_a [5];
  logic              tick;

  assign btn_a[0] = btn1;
  assign btn_a[1] = btn2;
  assign btn_a[2] = btn3;
  assign btn_a[3] = btn4;
  assign btn_a[4] = btn5;

  // STEP is entered exactly when the step counter holds its last value.
  assign tick = (state_q == STEP);

  always_comb begin
    state_d    = IDLE_WAIT;
    step_cnt_d = tick ? '0 : step_cnt_q + 1'b1;
    if (step_cnt_d == STEP_LAST) state_d = STEP;

    frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;

    pos_d   = pos_q;
    width_d = width_q;
    pwm_d   = '0;
    for (int k = 0; k < 5; k++) begin
      if (tick && sw) begin
        case (btn_a[k])
          2'b01:   if (pos_q[k] != 8'hFF) pos_d[k] = pos_q[k] + 8'd1;
          2'b10:   if (pos_q[k] != 8'h00) pos_d[k] = pos_q[k] - 8'd1;
          default: pos_d[k] = pos_q[k];
        endcase
      end
      if (frame_q == '0) width_d[k] = P_MIN + CNT_W'(pos_q[k]) * P_STEP;
      pwm_d[k] = (frame_q < width_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE_WAIT;
      step_cnt_q <= '0;
      frame_q    <= '0;
      pwm_q      <= '0;
      for (int k = 0; k < 5; k++) begin
        pos_q[k]   <= POS_INIT;
        width_q[k] <= W_INIT;
      end
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      frame_q    <= frame_d;
      pwm_q      <= pwm_d;
      for (int k = 0; k < 5; k++) begin
        pos_q[k]   <= pos_d[k];
        width_q[k] <= width_d[k];
      end
    end
  end

  always_comb begin
    lim = '0;
    for (int k = 0; k < 5; k++) lim[k] = (pos_q[k] == 8'h00) || (pos_q[k] == 8'hFF);
  end

  assign pos1 = pos_q[0];
  assign pos2 = pos_q[1];
  assign pos3 = pos_q[2];
  assign pos4 = pos_q[3];
  assign pos5 = pos_q[4];
  assign pwm  = pwm_q;

endmodule

// File: doc/servo_pos_driver.md
SERVO_POS_DRIVER -- requirements
Module: servo_pos_driver

Interface
REQ-001 Parameter STEP_DIV, default 500000: clock cycles per position step tick, 2 or more.
REQ-002 Parameter PWM_PERIOD, default 1000000: clock cycles per servo frame.
REQ-003 Parameter PULSE_MIN, default 50000: high-time in cycles at pos = 0.
REQ-004 Parameter PULSE_STEP, default 196: extra high-time cycles per position LSB; PULSE_MIN + 255*PULSE_STEP SHALL be less than PWM_PERIOD.
REQ-005 Parameter POS_INIT, default 8'h80: position loaded on reset.
REQ-006 Parameter CNT_W, default 20: width of the step and frame counters.
REQ-007 clk  in  1  single system clock; all logic is on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 sw  in  1  motion enable; 1 = steps applied, 0 = positions frozen.
REQ-010 btn1..btn5  in  2 each  per-joint command: 2'b01 increment, 2'b10 decrement, 2'b00 or 2'b11 hold.
REQ-011 pos1..pos5  out  8 each  current commanded joint position.
REQ-012 pwm  out  5  servo pulse per joint; bit k-1 belongs to joint k.
REQ-013 lim  out  5  bit k-1 is high when pos k is 8'h00 or 8'hFF.

Function
REQ-014 Step counter: counts 0..STEP_DIV-1 and wraps; tick is high for the one cycle where count = STEP_DIV-1; it runs regardless of sw.
REQ-015 Position update: on a tick edge with sw=1, each joint independently SHALL step by +1 on 2'b01, by -1 on 2'b10, and hold otherwise.
REQ-016 btn inputs SHALL be sampled only on tick cycles; activity between ticks is ignored.
REQ-017 Saturation: increment at 8'hFF and decrement at 8'h00 SHALL hold the value; no wrap-around.
REQ-018 Latency: pos changes on the same rising edge that samples the tick; pos is registered and stable all other cycles.
REQ-019 sw=0 on a tick edge: no position change; the step counter keeps running.
REQ-020 Frame counter: counts 0..PWM_PERIOD-1 and wraps; it is shared by all joints.
REQ-021 Width latch: at frame counter = 0, each joint latches width_k = PULSE_MIN + pos_k*PULSE_STEP (CNT_W bits, no overflow by REQ-004); pos changes mid-frame SHALL NOT alter the current frame.
REQ-022 pwm bit k-1 SHALL be registered high while frame counter < width_k, and low otherwise.
REQ-023 lim is combinational from the registered pos values.
REQ-024 State: IDLE_WAIT (counting toward tick) and STEP (tick cycle, update applied); STEP always returns to IDLE_WAIT after one cycle.

Reset
REQ-025 rst_n low SHALL asynchronously force: pos1..pos5 = POS_INIT, step and frame counters = 0, pwm = 5'b00000, widths = PULSE_MIN + POS_INIT*PULSE_STEP, state = IDLE_WAIT.
REQ-026 lim SHALL reflect POS_INIT during reset (5'b00000 for the default).
REQ-027 Reset asserted mid-frame or mid-step SHALL abort immediately with no partial update.
REQ-028 After rst_n rises, the first tick SHALL occur STEP_DIV cycles later and the first pwm high SHALL occur on the first cycle.

Verification
Bench parameters: STEP_DIV=4, PWM_PERIOD=300, PULSE_MIN=10, PULSE_STEP=1, POS_INIT=8'h80.
REQ-029 Reset release, btn all 00, sw=1 -> all pos stay 8'h80 and pwm high for exactly 138 cycles per 300-cycle frame.
REQ-030 btn1=01, sw=1, 10 ticks -> pos1=8'h8A, other joints 8'h80; changes occur only on tick edges, 4 cycles apart.
REQ-031 pos2 driven to 8'hFE, btn2=01 for 3 ticks -> pos2=8'hFF, lim[1]=1, no wrap; then btn2=10 for 1 tick -> pos2=8'hFE, lim[1]=0.
REQ-032 btn3=11, and separately sw=0 with btn3=01 -> pos3 unchanged in both cases; the step counter keeps running.
REQ-033 pos4 changed mid-frame -> pwm[3] width unchanged until the next frame start, then equals 10 + new pos4.
REQ-034 rst_n pulsed low mid-frame with pos5=8'h20 -> pos5=8'h80 and pwm=0 immediately, asynchronously; normal frames resume after release.
